// File: rtl/gate_truth_table_scanner.sv
// Self-test stage for the two-input gates block: walks a/b through all four
// vectors, checks y0..y7 against the truth table and reports mismatches.
module gate_truth_table_scanner #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [5:0] err_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] vec;
  logic [7:0] cnt;
  logic [7:0] expect_y;
  logic [7:0] mismatch;
  logic [3:0] miss_cnt;
  logic       launch;
  logic       sample;
  logic       last;

  assign a_out  = vec[1];
  assign b_out  = vec[0];
  assign launch = start && (state != SETTLE);
  assign sample = (state == SETTLE) && (cnt == 8'd0);
  assign last   = (vec == 2'd3);

  always_comb begin
    expect_y    = '0;
    expect_y[0] = a_out;
    expect_y[1] = a_out & b_out;
    expect_y[2] = a_out | b_out;
    expect_y[3] = a_out ^ b_out;
    expect_y[4] = ~b_out;
    expect_y[5] = ~(a_out & b_out);
    expect_y[6] = ~(a_out | b_out);
    expect_y[7] = ~(a_out ^ b_out);
  end

  assign mismatch = y_in ^ expect_y;

  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      miss_cnt = miss_cnt + 4'(mismatch[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (sample && last) state_nxt = DONE;
      DONE:    if (start) state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SETTLE);
    done = (state == DONE);
  end

  // Results accumulate only on the last cycle of each settle window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec       <= '0;
      cnt       <= '0;
      fail_mask <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (launch) begin
      vec       <= '0;
      cnt       <= RELOAD;
      fail_mask <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (sample) begin
      fail_mask <= fail_mask | mismatch;
      err_count <= err_count + 6'(miss_cnt);
      if (!last) begin
        vec <= vec + 2'd1;
        cnt <= RELOAD;
      end else begin
        pass <= ((fail_mask | mismatch) == 8'h00);
      end
    end else if (state == SETTLE) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule
